// File: rtl/sfq_phase_seq.sv
// Phase sequencer for an SFQ gate netlist: accepts one primary-input vector per epoch and walks a one-hot
//   strobe through NPHASES clock phases while holding that vector stable on pi_data.
// Latency: phase_en[0] is asserted the cycle after a vector is accepted. Back-to-back epochs have no bubble.
// Backpressure: in_ready is high only in IDLE or on the last phase of an epoch, and only while stop is low.
//
// Ports:
//   clk, rst               single clock; asynchronous active-high reset
//   in_valid/in_ready      input vector handshake; in_data is captured into pi_data on the transfer edge
//   stop                   synchronous abort of the running epoch; also blocks acceptance in IDLE
//   pi_data                vector driven to the gate netlist, stable for a whole epoch
//   phase_en, phase_idx    one-hot phase strobe and its binary index
//   epoch_start            pulse coincident with phase_en[0]
//   epoch_cnt              completed-epoch counter (wraps at 16 bits)
//   busy                   high while an epoch is running
module sfq_phase_seq #(
  parameter int NPHASES = 4,
  parameter int DATA_W  = 8,
  localparam int IDX_W  = $clog2(NPHASES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               stop,
  output logic [DATA_W-1:0]  pi_data,
  output logic [NPHASES-1:0] phase_en,
  output logic [IDX_W-1:0]   phase_idx,
  output logic               epoch_start,
  output logic [15:0]        epoch_cnt,
  output logic               busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NPHASES - 1);
  localparam logic [NPHASES-1:0] EN_FIRST = NPHASES'(1);

  state_t state;
  logic   last_phase;
  logic   accept;

  assign last_phase = (state == RUN) && (phase_idx == LAST_IDX);

  // A new vector may only enter when the netlist is not mid-epoch; stop always wins.
  assign in_ready = !rst && !stop && ((state == IDLE) || last_phase);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pi_data     <= '0;
      phase_en    <= '0;
      phase_idx   <= '0;
      epoch_start <= 1'b0;
      epoch_cnt   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= RUN;
            pi_data     <= in_data;
            phase_idx   <= '0;
            phase_en    <= EN_FIRST;
            epoch_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort: the partial epoch is dropped, pi_data keeps the last vector.
            state       <= IDLE;
            phase_idx   <= '0;
            phase_en    <= '0;
            epoch_start <= 1'b0;
            busy        <= 1'b0;
          end else if (phase_idx == LAST_IDX) begin
            epoch_cnt <= epoch_cnt + 16'd1;
            if (accept) begin
              // Chain straight into the next epoch without an idle cycle.
              pi_data     <= in_data;
              phase_idx   <= '0;
              phase_en    <= EN_FIRST;
              epoch_start <= 1'b1;
            end else begin
              state       <= IDLE;
              phase_idx   <= '0;
              phase_en    <= '0;
              epoch_start <= 1'b0;
              busy        <= 1'b0;
            end
          end else begin
            phase_idx   <= phase_idx + 1'b1;
            phase_en    <= phase_en << 1;
            epoch_start <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfq_phase_seq.sv
// Self-checking bench for sfq_phase_seq: table-driven vectors on a 4-phase instance, hand-written
//   sequences for async reset, counter wrap, and 2-/16-phase instances.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there as well.
module tb_sfq_phase_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-phase main instance
  logic       in_valid = 1'b0, stop = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, epoch_start, busy;
  logic [7:0] pi_data;
  logic [3:0] phase_en;
  logic [1:0] phase_idx;
  logic [15:0] epoch_cnt;

  sfq_phase_seq #(.NPHASES(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stop(stop), .pi_data(pi_data), .phase_en(phase_en), .phase_idx(phase_idx),
    .epoch_start(epoch_start), .epoch_cnt(epoch_cnt), .busy(busy)
  );

  // 2-phase and 16-phase instances share data/stop, each has its own valid
  logic        sw_stop = 1'b0;
  logic [7:0]  sw_data = 8'h5A;
  logic        v2 = 1'b0, v16 = 1'b0;
  logic        rdy2, es2, busy2, rdy16, es16, busy16;
  logic [7:0]  pi2, pi16;
  logic [1:0]  en2;
  logic [0:0]  idx2;
  logic [15:0] en16;
  logic [3:0]  idx16;
  logic [15:0] cnt2, cnt16;

  sfq_phase_seq #(.NPHASES(2), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(sw_data), .in_ready(rdy2),
    .stop(sw_stop), .pi_data(pi2), .phase_en(en2), .phase_idx(idx2),
    .epoch_start(es2), .epoch_cnt(cnt2), .busy(busy2)
  );

  sfq_phase_seq #(.NPHASES(16), .DATA_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_data(sw_data), .in_ready(rdy16),
    .stop(sw_stop), .pi_data(pi16), .phase_en(en16), .phase_idx(idx16),
    .epoch_start(es16), .epoch_cnt(cnt16), .busy(busy16)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One record per clock: inputs applied before the edge, in_ready checked before the edge,
  // registered outputs checked after it.
  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        stp;
    logic        rdy;
    logic [3:0]  en;
    logic [1:0]  idx;
    logic        es;
    logic        bsy;
    logic [7:0]  pi;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vld, input logic [7:0] dat, input logic stp, input logic rdy,
                     input logic [3:0] en, input logic [1:0] idx, input logic es, input logic bsy,
                     input logic [7:0] pi, input logic [15:0] cnt);
    vec_t v;
    v.vld = vld; v.dat = dat; v.stp = stp; v.rdy = rdy; v.en = en; v.idx = idx;
    v.es = es; v.bsy = bsy; v.pi = pi; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   vld dat    stp rdy en       idx es bsy pi     cnt
    // single vector 0xA5
    add(1, 8'hA5, 0, 1, 4'b0001, 0, 1, 1, 8'hA5, 0);
    add(0, 8'h00, 0, 0, 4'b0010, 1, 0, 1, 8'hA5, 0);
    add(0, 8'h00, 0, 0, 4'b0100, 2, 0, 1, 8'hA5, 0);
    add(0, 8'h00, 0, 0, 4'b1000, 3, 0, 1, 8'hA5, 0);
    add(0, 8'h00, 0, 1, 4'b0000, 0, 0, 0, 8'hA5, 1);
    // stop in IDLE blocks acceptance
    add(1, 8'h77, 1, 0, 4'b0000, 0, 0, 0, 8'hA5, 1);
    // back-to-back 0x01, 0x02, 0x03 with valid held high
    add(1, 8'h01, 0, 1, 4'b0001, 0, 1, 1, 8'h01, 1);
    add(1, 8'h02, 0, 0, 4'b0010, 1, 0, 1, 8'h01, 1);
    add(1, 8'h02, 0, 0, 4'b0100, 2, 0, 1, 8'h01, 1);
    add(1, 8'h02, 0, 0, 4'b1000, 3, 0, 1, 8'h01, 1);
    add(1, 8'h02, 0, 1, 4'b0001, 0, 1, 1, 8'h02, 2);
    add(1, 8'h03, 0, 0, 4'b0010, 1, 0, 1, 8'h02, 2);
    add(1, 8'h03, 0, 0, 4'b0100, 2, 0, 1, 8'h02, 2);
    add(1, 8'h03, 0, 0, 4'b1000, 3, 0, 1, 8'h02, 2);
    add(1, 8'h03, 0, 1, 4'b0001, 0, 1, 1, 8'h03, 3);
    add(0, 8'h00, 0, 0, 4'b0010, 1, 0, 1, 8'h03, 3);
    add(0, 8'h00, 0, 0, 4'b0100, 2, 0, 1, 8'h03, 3);
    add(0, 8'h00, 0, 0, 4'b1000, 3, 0, 1, 8'h03, 3);
    add(0, 8'h00, 0, 1, 4'b0000, 0, 0, 0, 8'h03, 4);
    // abort during phase 2
    add(1, 8'h55, 0, 1, 4'b0001, 0, 1, 1, 8'h55, 4);
    add(0, 8'h00, 0, 0, 4'b0010, 1, 0, 1, 8'h55, 4);
    add(0, 8'h00, 0, 0, 4'b0100, 2, 0, 1, 8'h55, 4);
    add(0, 8'h00, 1, 0, 4'b0000, 0, 0, 0, 8'h55, 4);
    // stop together with valid on the last phase: no transfer, not counted
    add(1, 8'h66, 0, 1, 4'b0001, 0, 1, 1, 8'h66, 4);
    add(0, 8'h00, 0, 0, 4'b0010, 1, 0, 1, 8'h66, 4);
    add(0, 8'h00, 0, 0, 4'b0100, 2, 0, 1, 8'h66, 4);
    add(0, 8'h00, 0, 0, 4'b1000, 3, 0, 1, 8'h66, 4);
    add(1, 8'h99, 1, 0, 4'b0000, 0, 0, 0, 8'h66, 4);
    add(0, 8'h00, 0, 1, 4'b0000, 0, 0, 0, 8'h66, 4);

    // ---- reset state, checked while rst is held high ----
    #1 rst = 1'b1;
    #2;
    check("rst in_ready", in_ready, 0);
    check("rst pi_data", pi_data, 0);
    check("rst phase_en", phase_en, 0);
    check("rst phase_idx", phase_idx, 0);
    check("rst epoch_start", epoch_start, 0);
    check("rst epoch_cnt", epoch_cnt, 0);
    check("rst busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;

    // ---- table-driven sequence ----
    foreach (tbl[i]) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].dat;
      stop     = tbl[i].stp;
      #1;
      check($sformatf("v%0d in_ready", i), in_ready, tbl[i].rdy);
      tick();
      check($sformatf("v%0d phase_en", i), phase_en, tbl[i].en);
      check($sformatf("v%0d phase_idx", i), phase_idx, tbl[i].idx);
      check($sformatf("v%0d epoch_start", i), epoch_start, tbl[i].es);
      check($sformatf("v%0d busy", i), busy, tbl[i].bsy);
      check($sformatf("v%0d pi_data", i), pi_data, tbl[i].pi);
      check($sformatf("v%0d epoch_cnt", i), epoch_cnt, tbl[i].cnt);
    end
    in_valid = 1'b0;
    stop = 1'b0;

    // ---- async reset between edges during phase 1 ----
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();                       // accepted, phase 0
    in_valid = 1'b0;
    tick();                       // phase 1
    check("ar pre phase_idx", phase_idx, 1);
    #2 rst = 1'b1;
    #1;
    check("ar phase_en", phase_en, 0);
    check("ar busy", busy, 0);
    check("ar pi_data", pi_data, 0);
    check("ar epoch_cnt", epoch_cnt, 0);
    check("ar in_ready", in_ready, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1;
    check("ar post in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("ar 3C pi_data", pi_data, 8'h3C);
    check("ar 3C phase_en", phase_en, 4'b0001);
    check("ar 3C epoch_start", epoch_start, 1);
    check("ar 3C epoch_cnt", epoch_cnt, 0);
    repeat (4) tick();
    check("ar 3C done busy", busy, 0);
    check("ar 3C done cnt", epoch_cnt, 1);

    // ---- epoch counter wrap ----
    force dut.epoch_cnt = 16'hFFFF;
    #1;
    release dut.epoch_cnt;
    #1;
    in_valid = 1'b1;
    in_data  = 8'hE1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("wrap last phase cnt", epoch_cnt, 16'hFFFF);
    tick();
    check("wrap cnt", epoch_cnt, 16'h0000);
    check("wrap busy", busy, 0);

    // ---- 2-phase instance: two chained epochs ----
    v2 = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("n2 c%0d idx", c), idx2, c % 2);
      check($sformatf("n2 c%0d en", c), en2, 1 << (c % 2));
      check($sformatf("n2 c%0d busy", c), busy2, 1);
      check($sformatf("n2 c%0d es", c), es2, (c % 2) == 0);
      if (c == 2) v2 = 1'b0;
      tick();
    end
    check("n2 end busy", busy2, 0);
    check("n2 end cnt", cnt2, 2);

    // ---- 16-phase instance: two chained epochs ----
    v16 = 1'b1;
    tick();
    for (int c = 0; c < 32; c++) begin
      check($sformatf("n16 c%0d idx", c), idx16, c % 16);
      check($sformatf("n16 c%0d en", c), en16, 1 << (c % 16));
      check($sformatf("n16 c%0d busy", c), busy16, 1);
      check($sformatf("n16 c%0d es", c), es16, (c % 16) == 0);
      if (c == 16) v16 = 1'b0;
      tick();
    end
    check("n16 end busy", busy16, 0);
    check("n16 end cnt", cnt16, 2);
    check("n16 pi_data", pi16, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
